// File: rtl/alu_seq_divider_if.sv
// Start/busy/done handshake and result bus between the execute stage and the
// sequential divider.
interface alu_seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, is_signed, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Iterative restoring divider for div/divu: one subtract step per clock on
// operand magnitudes, with the signs re-applied in a final fix-up cycle.
module alu_seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  alu_seq_divider_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  typedef struct packed {
    logic             q_neg;
    logic             r_neg;
    logic             dz;
    logic             ov;
    logic [WIDTH-1:0] raw_dvd;
  } op_ctx_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state, w_next;
  op_ctx_t          r_ctx;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [WIDTH-1:0] r_q_out, r_r_out;
  logic             r_done, r_dz_out, r_ov_out;

  logic             w_accept;
  logic             w_dvd_neg, w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_trial;

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_dvd_neg = bus.is_signed && bus.dividend[WIDTH-1];
  assign w_dvs_neg = bus.is_signed && bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
  assign w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;

  // rem stays below the divisor, so a successful trial always fits in WIDTH bits
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_trial = w_shift[WIDTH-1:0] - r_dvs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = (bus.divisor == '0) ? S_FIX : S_RUN;
      S_RUN:  if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctx <= '0;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (w_accept) begin
      r_ctx.q_neg   <= w_dvd_neg ^ w_dvs_neg;
      r_ctx.r_neg   <= w_dvd_neg;
      r_ctx.dz      <= (bus.divisor == '0);
      r_ctx.ov      <= bus.is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
      r_ctx.raw_dvd <= bus.dividend;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= w_dvd_mag;
      r_dvs         <= w_dvs_mag;
    end else if (r_state == S_RUN) begin
      r_rem <= w_ge ? w_trial : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Results and flags move only on the fix-up edge and hold otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_out  <= '0;
      r_r_out  <= '0;
      r_dz_out <= 1'b0;
      r_ov_out <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      if (r_state == S_FIX) begin
        if (r_ctx.dz) begin
          r_q_out <= '1;
          r_r_out <= r_ctx.raw_dvd;
        end else begin
          r_q_out <= r_ctx.q_neg ? -r_quo : r_quo;
          r_r_out <= r_ctx.r_neg ? -r_rem : r_rem;
        end
        r_dz_out <= r_ctx.dz;
        r_ov_out <= r_ctx.ov;
      end
    end
  end

  assign bus.ready       = (r_state == S_IDLE);
  assign bus.busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus.done        = r_done;
  assign bus.quotient    = r_q_out;
  assign bus.remainder   = r_r_out;
  assign bus.div_by_zero = r_dz_out;
  assign bus.overflow    = r_ov_out;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Scoreboard bench for alu_seq_divider: directed corner cases plus random
// operands checked against a plain-arithmetic division model.
module tb_alu_seq_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_divider_if #(.WIDTH(32)) bus();

  alu_seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;
  logic [65:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // {quotient, remainder, div_by_zero, overflow}
  function automatic logic [65:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 0) return {32'hFFFF_FFFF, a, 1'b1, 1'b0};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0, 1'b0, 1'b1};
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r, 1'b0, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      logic [65:0] e;
      done_seen++;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard");
      end else begin
        e = exp_q.pop_front();
        chk("quotient",    bus.quotient,          e[65:34]);
        chk("remainder",   bus.remainder,         e[33:2]);
        chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e[1]});
        chk("overflow",    {31'b0, bus.overflow},    {31'b0, e[0]});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
    if (push) exp_q.push_back(model(a, b, s));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called #1 after the start-sampling edge; lat counts edges including that one
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1; busy_n = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done after %0d edges, required done", lat);
    end
  endtask

  initial begin
    int lat, bn, d0;
    logic [31:0] a, b;
    logic s;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_busy",  {31'b0, bus.busy},  32'd0);
    chk("rst_done",  {31'b0, bus.done},  32'd0);
    chk("rst_quo",   bus.quotient,  32'd0);
    chk("rst_rem",   bus.remainder, 32'd0);
    chk("rst_flags", {30'b0, bus.div_by_zero, bus.overflow}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    issue(32'd100, 32'd7, 1'b0, 1'b1);
    wait_done(lat, bn);
    chk("lat_100_7", lat, 32'd34);
    chk("busy_100_7", bn, 32'd33);

    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);  wait_done(lat, bn);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);  wait_done(lat, bn);

    issue(32'h1234_5678, 32'd0, 1'b0, 1'b1);  wait_done(lat, bn);
    chk("lat_dz_u", lat, 32'd2);
    issue(32'h1234_5678, 32'd0, 1'b1, 1'b1);  wait_done(lat, bn);
    chk("lat_dz_s", lat, 32'd2);

    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_done(lat, bn);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_done(lat, bn);

    // start during RUN is ignored; results hold until the next fix-up
    issue(32'd50, 32'd5, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd99; bus.divisor = 32'd9;
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    chk("hold_quo_in_run", bus.quotient, 32'd0);
    chk("hold_rem_in_run", bus.remainder, 32'h8000_0000);
    wait_done(lat, bn);
    // back-to-back start in the done cycle
    issue(32'd99, 32'd9, 1'b0, 1'b1);
    wait_done(lat, bn);
    chk("lat_b2b", lat, 32'd34);

    // reset mid-run discards the op
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_quo",   bus.quotient,  32'd0);
    chk("mid_rst_rem",   bus.remainder, 32'd0);
    chk("mid_rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("mid_rst_busy",  {31'b0, bus.busy},  32'd0);
    d0 = done_seen;
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_seen, d0);
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    wait_done(lat, bn);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, 1'b1);
      wait_done(lat, bn);
      chk("lat_rand", lat, (b == 0) ? 32'd2 : 32'd34);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
